register_file_scoreboard: RTL and testbench
===========================================

Name: register_file_scoreboard

Overview:
- Parametrised successor to the CPU's 32x32 integer register file.
- Provides two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero.
- Adds a per-register pending-write scoreboard for hazard detection, plus a sequenced clear engine for pipeline flush and debug scrub.
- Sits in the decode stage. Reads feed the ALU operand muxes; the write port is driven from writeback.

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH, 32, number of registers. Power of two, minimum 2. Register 0 is constant zero.
- ADDR_W, $clog2(DEPTH), address width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_ena  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd_addr0  input  ADDR_W  read port 0 address.
- rd_data0  output  WIDTH  read port 0 data (combinational).
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_data1  output  WIDTH  read port 1 data (combinational).
- mark_ena  input  1  set the pending bit of mark_addr (instruction issued with this destination).
- mark_addr  input  ADDR_W  destination being marked.
- rd_pending0  output  1  pending bit of rd_addr0 (combinational).
- rd_pending1  output  1  pending bit of rd_addr1 (combinational).
- clear_req  input  1  start a clear sequence.
- clear_busy  output  1  high while the clear engine runs.

Behaviour:
- Reset (async, rst=1): all registers = 0, all pending bits = 0, FSM = IDLE, clear_busy = 0. Read outputs therefore read 0 during reset.
- Register 0:
  - Reads of address 0 always return 0 with rd_pendingN = 0.
  - Writes and marks to address 0 are dropped.
- Write: when wr_ena=1 and the FSM is IDLE, reg[wr_addr] <= wr_data at the clock edge, and pending[wr_addr] <= 0.
- Mark: when mark_ena=1 and the FSM is IDLE, pending[mark_addr] <= 1.
- Same edge, write and mark to the same address:
  - Data is written.
  - Pending ends at 1, because the mark wins: a newer producer has issued.
- Same edge, different addresses: both take effect.
- Reads: rd_dataN = reg[rd_addrN] and rd_pendingN = pending[rd_addrN], purely combinational. Without the bypass option, the value is the one from before the edge.
- FSM states:
  - IDLE: clear_busy=0. If clear_req=1, go to CLEAR, set ptr <= 1 and set all pending bits to 0 on that edge.
  - CLEAR: clear_busy=1.
    - Each cycle reg[ptr] <= 0 and ptr <= ptr+1.
    - When ptr == DEPTH-1, clear that register and go to IDLE.
    - Sequence length is DEPTH-1 cycles in CLEAR; for DEPTH=32, clear_busy is high for 31 cycles.
- During CLEAR:
  - wr_ena, mark_ena and clear_req are ignored (no effect, no queuing).
  - Reads stay live and return the partially cleared contents.
- clear_req held high on the final CLEAR cycle does not restart the sequence; it must be seen in IDLE.
- Reset asserted mid-CLEAR: immediate return to IDLE with all state zeroed.
- ptr is ADDR_W bits wide; it never wraps because the terminal compare happens at DEPTH-1.
- Out-of-range addresses are not possible because DEPTH is a power of two.

Optional Feature:
- Macro: REGISTER_FILE_BYPASS_EN
- Defined:
  - Write-through forwarding. If wr_ena=1, FSM=IDLE, wr_addr!=0 and rd_addrN==wr_addr, then rd_dataN = wr_data and rd_pendingN = mark-wins result (1 if mark_ena hits the same address, else 0), in the same cycle.
- Not defined:
  - Reads return stored state only.
  - New data is visible the cycle after the write edge.

Test Plan:
- After reset, write 0xDEADBEEF to x5; read rd_addr0=5 next cycle -> rd_data0=0xDEADBEEF, rd_pending0=0.
- Write 0x12345678 to x0 -> rd_data0 for addr 0 stays 0x00000000 and rd_pending0=0.
- mark x7, then rd_addr1=7 -> rd_pending1=1. Write x7=0x55 two cycles later -> rd_pending1=0 and rd_data1=0x55. Separately, mark and write x7 on the same edge -> pending stays 1.
- Fill x1..x31 with their own index, pulse clear_req -> clear_busy high exactly 31 cycles. During that window, writes and marks to x3 have no effect. Afterwards all registers read 0 and no register is pending.
- Assert rst on the 10th CLEAR cycle -> clear_busy drops immediately, all registers 0, FSM accepts a write on the first edge after rst deasserts.
- With REGISTER_FILE_BYPASS_EN, write x9=0xA5A5A5A5 with rd_addr0=9 in the same cycle -> rd_data0=0xA5A5A5A5 before the edge. Without the macro -> old value before the edge, 0xA5A5A5A5 after it.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// -----------------------------------------------------------------------------
// register_file_scoreboard
//
// Purpose:
//   Parametrised integer register file for the decode stage. It provides two
//   combinational read ports and one synchronous write port, and register 0
//   always reads as zero. A pending bit per register records destinations
//   whose producer has issued but not yet written back, for hazard detection.
//   A sequenced clear engine zeroes the file one register per cycle for
//   pipeline flush and debug scrub.
//
// Parameters:
//   WIDTH   data width of each register
//   DEPTH   number of registers (power of two, >= 2)
//   ADDR_W  address width, derived from DEPTH (do not override)
//
// Ports:
//   clk          system clock, rising-edge
//   rst          asynchronous active-high reset
//   wr_ena       write enable (writeback)
//   wr_addr      write address
//   wr_data      write data
//   rd_addr0/1   read port addresses
//   rd_data0/1   read port data (combinational)
//   mark_ena     set pending bit of mark_addr (instruction issued)
//   mark_addr    destination being marked
//   rd_pending0/1 pending bit of the addressed register (combinational)
//   clear_req    start a clear sequence (honoured only when idle)
//   clear_busy   high while the clear engine runs
//
// Optional feature:
//   REGISTER_FILE_BYPASS_EN  when defined, a write accepted this cycle is
//   forwarded to any read port addressing the same register, along with the
//   pending bit that register will hold after the edge.
// -----------------------------------------------------------------------------
module register_file_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [WIDTH-1:0]  rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic              mark_ena,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              rd_pending0,
    output logic              rd_pending1,
    input  logic              clear_req,
    output logic              clear_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]    pending;

    logic                wr_hit;
    logic                mark_hit;

    // Writes and marks only count when the engine is idle and the target is
    // not the hardwired zero register.
    assign wr_hit   = wr_ena   && (state == IDLE) && (wr_addr   != '0);
    assign mark_hit = mark_ena && (state == IDLE) && (mark_addr != '0);

    // Register storage, scoreboard and clear engine share one sequential
    // block so that the precedence between write, mark and clear is explicit.
    // Within IDLE the mark is applied after the write so a same-address mark
    // wins (a newer producer has issued); a clear request then overrides all
    // pending bits because the whole file is about to be scrubbed. In CLEAR
    // the external controls are ignored and the pointer walks 1..DEPTH-1,
    // returning to IDLE after zeroing the last register, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs       <= '{default: '0};
            pending    <= '0;
            state      <= IDLE;
            ptr        <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_hit) begin
                        regs[wr_addr]    <= wr_data;
                        pending[wr_addr] <= 1'b0;
                    end
                    if (mark_hit) begin
                        pending[mark_addr] <= 1'b1;
                    end
                    if (clear_req) begin
                        pending    <= '0;
                        ptr        <= ADDR_W'(1);
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    if (ptr == LAST_ADDR) begin
                        ptr        <= '0;
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Read port 0: stored value, with address 0 forced to zero and not
    // pending. With the bypass option a same-cycle accepted write is
    // forwarded together with its post-edge pending bit.
    always_comb begin
        rd_data0    = '0;
        rd_pending0 = 1'b0;
        if (rd_addr0 != '0) begin
            rd_data0    = regs[rd_addr0];
            rd_pending0 = pending[rd_addr0];
        end
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_hit && (rd_addr0 == wr_addr)) begin
            rd_data0    = wr_data;
            rd_pending0 = mark_hit && (mark_addr == wr_addr);
        end
`endif
    end

    // Read port 1: identical behaviour to port 0.
    always_comb begin
        rd_data1    = '0;
        rd_pending1 = 1'b0;
        if (rd_addr1 != '0) begin
            rd_data1    = regs[rd_addr1];
            rd_pending1 = pending[rd_addr1];
        end
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_hit && (rd_addr1 == wr_addr)) begin
            rd_data1    = wr_data;
            rd_pending1 = mark_hit && (mark_addr == wr_addr);
        end
`endif
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_register_file_scoreboard
//
// Self-checking bench for register_file_scoreboard (default parameters).
// A behavioural model holds the register contents as a plain array, the
// pending bits as a bit array, and the clear engine as a "cycles left" count.
// Honours REGISTER_FILE_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_register_file_scoreboard;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic             wr_ena;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr0;
    logic [WIDTH-1:0] rd_data0;
    logic [AW-1:0]    rd_addr1;
    logic [WIDTH-1:0] rd_data1;
    logic             mark_ena;
    logic [AW-1:0]    mark_addr;
    logic             rd_pending0;
    logic             rd_pending1;
    logic             clear_req;
    logic             clear_busy;

    int checksTotal;
    int checksPassed;

    logic [WIDTH-1:0] mRegs [DEPTH];
    bit               mPend [DEPTH];
    int               clearLeft;
    int               clearPtr;

    register_file_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr0   (rd_addr0),
        .rd_data0   (rd_data0),
        .rd_addr1   (rd_addr1),
        .rd_data1   (rd_data1),
        .mark_ena   (mark_ena),
        .mark_addr  (mark_addr),
        .rd_pending0(rd_pending0),
        .rd_pending1(rd_pending1),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Reference model: everything returns to zero.
    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mRegs[i] = '0;
            mPend[i] = 1'b0;
        end
        clearLeft = 0;
        clearPtr  = 0;
    endtask

    // What a read port should show right now, before the coming edge.
    task automatic modelRead(input logic [AW-1:0] a, output logic [WIDTH-1:0] d,
                             output logic p);
        d = (a == 0) ? '0 : mRegs[a];
        p = (a == 0) ? 1'b0 : mPend[a];
`ifdef REGISTER_FILE_BYPASS_EN
        if (clearLeft == 0 && wr_ena && wr_addr != 0 && a == wr_addr) begin
            d = wr_data;
            p = mark_ena && (mark_addr == wr_addr);
        end
`endif
    endtask

    // Effect of one rising edge given the currently applied inputs.
    task automatic modelEdge();
        if (clearLeft == 0) begin
            if (wr_ena && wr_addr != 0) begin
                mRegs[wr_addr] = wr_data;
                mPend[wr_addr] = 1'b0;
            end
            if (mark_ena && mark_addr != 0) mPend[mark_addr] = 1'b1;
            if (clear_req) begin
                for (int i = 0; i < DEPTH; i++) mPend[i] = 1'b0;
                clearPtr  = 1;
                clearLeft = DEPTH - 1;
            end
        end else begin
            mRegs[clearPtr] = '0;
            clearPtr++;
            clearLeft--;
        end
    endtask

    // Drive one cycle of inputs on the falling edge, compare every output
    // against the model before the rising edge, then advance the model.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [WIDTH-1:0] wd,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                 input logic me, input logic [AW-1:0] ma,
                                 input logic cr);
        logic [WIDTH-1:0] d0, d1;
        logic             p0, p1;
        @(negedge clk);
        wr_ena    = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr0  = ra0;
        rd_addr1  = ra1;
        mark_ena  = me;
        mark_addr = ma;
        clear_req = cr;
        #1;
        modelRead(ra0, d0, p0);
        modelRead(ra1, d1, p1);
        checkOutput("rd_data0", rd_data0, d0);
        checkOutput("rd_pending0", {31'b0, rd_pending0}, {31'b0, p0});
        checkOutput("rd_data1", rd_data1, d1);
        checkOutput("rd_pending1", {31'b0, rd_pending1}, {31'b0, p1});
        checkOutput("clear_busy", {31'b0, clear_busy}, {31'b0, clearLeft != 0});
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleRead(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        applyStimulus(1'b0, '0, '0, ra0, ra1, 1'b0, '0, 1'b0);
    endtask

    int busyCount;

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        rst       = 1'b1;
        wr_ena    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr0  = 5'd5;
        rd_addr1  = 5'd31;
        mark_ena  = 1'b0;
        mark_addr = '0;
        clear_req = 1'b0;
        modelReset();

        // Reset state.
        #12;
        checkOutput("reset_rd_data0", rd_data0, 32'h0);
        checkOutput("reset_rd_data1", rd_data1, 32'h0);
        checkOutput("reset_busy", {31'b0, clear_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write and read-back.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, '0, 1'b0);
        idleRead(5'd5, 5'd0);
        checkOutput("x5_data", rd_data0, 32'hDEADBEEF);
        checkOutput("x5_pending", {31'b0, rd_pending0}, 32'h0);

        // Writes and marks to x0 are dropped.
        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        idleRead(5'd0, 5'd0);
        checkOutput("x0_data", rd_data0, 32'h0);
        checkOutput("x0_pending", {31'b0, rd_pending0}, 32'h0);

        // Mark x7, then write it two cycles later.
        applyStimulus(1'b0, '0, '0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
        idleRead(5'd0, 5'd7);
        checkOutput("x7_marked", {31'b0, rd_pending1}, 32'h1);
        applyStimulus(1'b1, 5'd7, 32'h55, 5'd0, 5'd7, 1'b0, '0, 1'b0);
        idleRead(5'd0, 5'd7);
        checkOutput("x7_written_pending", {31'b0, rd_pending1}, 32'h0);
        checkOutput("x7_written_data", rd_data1, 32'h55);

        // Same-edge mark and write: mark wins, data still written.
        applyStimulus(1'b1, 5'd7, 32'h77, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
        idleRead(5'd0, 5'd7);
        checkOutput("x7_markwins_pending", {31'b0, rd_pending1}, 32'h1);
        checkOutput("x7_markwins_data", rd_data1, 32'h77);

        // Same-edge write and mark to different addresses.
        applyStimulus(1'b1, 5'd10, 32'hCAFE0010, 5'd10, 5'd11, 1'b1, 5'd11, 1'b0);
        idleRead(5'd10, 5'd11);

        // Same-cycle visibility of a write (forwarded only with bypass).
        applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b0, '0, 1'b0);
        idleRead(5'd9, 5'd0);
        checkOutput("x9_after_edge", rd_data0, 32'hA5A5A5A5);

        // Fill x1..x31 with their own index, mark a few, then clear.
        for (int i = 1; i < DEPTH; i++)
            applyStimulus(1'b1, AW'(i), WIDTH'(i), AW'(i), AW'(DEPTH - i), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 5'd3, 5'd20, 1'b1, 5'd20, 1'b0);
        applyStimulus(1'b0, '0, '0, 5'd3, 5'd20, 1'b0, '0, 1'b1);
        busyCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (!clear_busy) break;
            busyCount++;
            applyStimulus(1'b1, 5'd3, 32'hBAD00003, 5'd3, AW'($urandom_range(0, 31)),
                          1'b1, 5'd3, (i == 30));
        end
        checkOutput("busy_length", busyCount, 32'd31);
        for (int i = 0; i < DEPTH; i += 2) idleRead(AW'(i), AW'(i + 1));
        idleRead(5'd3, 5'd20);
        checkOutput("x3_after_clear", rd_data0, 32'h0);
        checkOutput("x3_pending_after_clear", {31'b0, rd_pending0}, 32'h0);

        // Reset in the middle of a clear sequence.
        applyStimulus(1'b1, 5'd25, 32'h25252525, 5'd25, 5'd0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 5'd25, 5'd0, 1'b1, 5'd25, 1'b1);
        for (int i = 0; i < 9; i++) idleRead(5'd25, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midclear_reset_busy", {31'b0, clear_busy}, 32'h0);
        checkOutput("midclear_reset_x25", rd_data0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 5'd4, 32'h44444444, 5'd4, 5'd0, 1'b0, '0, 1'b0);
        idleRead(5'd4, 5'd25);
        checkOutput("post_reset_write", rd_data0, 32'h44444444);

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 1) == 1, AW'($urandom), $urandom,
                          AW'($urandom), AW'($urandom),
                          $urandom_range(0, 2) == 0, AW'($urandom),
                          $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("%0d/%0d checks passed", checksPassed, checksTotal + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
